// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon round controller.
package simon_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCapture,
        StLoad,
        StShowOn,
        StShowOff,
        StWaitIn,
        StRoundUp,
        StWin,
        StLose
    } state_e;

    typedef logic [1:0] colour_t;

    localparam int unsigned MAX_ROUND = 4;

    function automatic logic [3:0] colour_onehot(colour_t c);
        return 4'b0001 << c;
    endfunction

    // Colour k occupies seq[2k+1:2k].
    function automatic colour_t colour_at(logic [7:0] seq, logic [1:0] k);
        return colour_t'(seq >> {k, 1'b0});
    endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module simon_tick_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/simon_round_controller.sv
// Simon game sequencer: captures an RNG value, plays rounds 1..4, checks presses.
// Optional press timeout in WAIT_IN is enabled by defining SIMON_TIMEOUT_EN.
module simon_round_controller
    import simon_pkg::*;
#(
    parameter int unsigned STEP_TICKS    = 50_000_000,
    parameter int unsigned GAP_TICKS     = 25_000_000,
    parameter int unsigned TIMEOUT_TICKS = 250_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_btn_i,
    input  logic [7:0] seq_in_i,
    input  logic [3:0] btn_i,
    output logic       rng_capture_o,
    output logic [3:0] led_o,
    output logic [2:0] round_o,
    output logic       busy_o,
    output logic       win_o,
    output logic       lose_o
);

    localparam int unsigned MaxSg    = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int unsigned MaxTicks = (MaxSg > TIMEOUT_TICKS) ? MaxSg : TIMEOUT_TICKS;
    localparam int unsigned TimerW   = $clog2(MaxTicks + 1);

    localparam logic [TimerW-1:0] StepLoad = TimerW'(STEP_TICKS - 1);
    localparam logic [TimerW-1:0] GapLoad  = TimerW'(GAP_TICKS - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_TICKS - 1);
`endif

    state_e      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  round_q, round_d;

    logic        tmr_load;
    logic [TimerW-1:0] tmr_value;
    logic        tmr_done;

    logic        rng_capture_q, rng_capture_d;
    logic [3:0]  led_q, led_d;
    logic        busy_q, busy_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;

    logic [3:0]  expected_btn;
    assign expected_btn = colour_onehot(colour_at(seq_q, idx_q));

    simon_tick_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (tmr_load),
        .value_i(tmr_value),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            seq_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        step_d    = step_q;
        idx_d     = idx_q;
        round_d   = round_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            StIdle, StWin, StLose: begin
                if (start_btn_i) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StLoad;
            StLoad: begin
                seq_d     = seq_in_i;
                round_d   = 3'd1;
                step_d    = '0;
                state_d   = StShowOn;
                tmr_load  = 1'b1;
                tmr_value = StepLoad;
            end
            StShowOn: begin
                if (tmr_done) begin
                    state_d   = StShowOff;
                    tmr_load  = 1'b1;
                    tmr_value = GapLoad;
                end
            end
            StShowOff: begin
                if (tmr_done) begin
                    step_d = step_q + 2'd1;
                    if ({1'b0, step_q} + 3'd1 == round_q) begin
                        state_d = StWaitIn;
                        idx_d   = '0;
`ifdef SIMON_TIMEOUT_EN
                        tmr_load  = 1'b1;
                        tmr_value = TimeoutLoad;
`endif
                    end else begin
                        state_d   = StShowOn;
                        tmr_load  = 1'b1;
                        tmr_value = StepLoad;
                    end
                end
            end
            StWaitIn: begin
                // A press always wins over a simultaneous timeout expiry.
                if (btn_i != '0) begin
                    if (btn_i == expected_btn) begin
                        if ({1'b0, idx_q} + 3'd1 == round_q) begin
                            state_d   = StRoundUp;
                            tmr_load  = 1'b1;
                            tmr_value = GapLoad;
                        end else begin
                            idx_d = idx_q + 2'd1;
`ifdef SIMON_TIMEOUT_EN
                            tmr_load  = 1'b1;
                            tmr_value = TimeoutLoad;
`endif
                        end
                    end else begin
                        state_d = StLose;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tmr_done) begin
                    state_d = StLose;
                end
`endif
            end
            StRoundUp: begin
                if (round_q == 3'(MAX_ROUND)) begin
                    state_d = StWin;
                end else if (tmr_done) begin
                    round_d   = round_q + 3'd1;
                    step_d    = '0;
                    state_d   = StShowOn;
                    tmr_load  = 1'b1;
                    tmr_value = StepLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        rng_capture_d = (state_d == StCapture);
        led_d         = '0;
        if (state_d == StShowOn) begin
            led_d = colour_onehot(colour_at(seq_d, step_d));
        end else if (state_d == StWin) begin
            led_d = 4'hF;
        end
        busy_d = !(state_d inside {StIdle, StWin, StLose});
        win_d  = (state_d == StWin);
        lose_d = (state_d == StLose);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rng_capture_q <= 1'b0;
            led_q         <= '0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            rng_capture_q <= rng_capture_d;
            led_q         <= led_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    assign rng_capture_o = rng_capture_q;
    assign led_o         = led_q;
    assign round_o       = round_q;
    assign busy_o        = busy_q;
    assign win_o         = win_q;
    assign lose_o        = lose_q;

endmodule
